pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed stall/flush pipeline registers (freg/dreg/rreg/ireg/ereg/creg).
- Carries a MACHINE_WIDTH-lane bundle between two stages using a valid/ready handshake instead of global stall lines.
- Holds up to DEPTH bundles in a small circular buffer, so back-pressure does not cost a bubble.
- Supports whole-stage flush and per-lane valid masks; empty bundles are squashed.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stage_buf_if.sv | 33 +++
 rtl/pipe_ring_ptr.sv | 26 ++
 rtl/pipe_stage_buf.sv | 90 +++++++++
 tb/tb_pipe_stage_buf.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: lane count, per-stage lane payloads, bundle shape.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package pipe_pkg;

   // Lanes per bundle follow the machine width.
   localparam int MACHINE_WIDTH = 4;
   localparam int LANES_DEFAULT = MACHINE_WIDTH;

   // Per-lane stage payloads; buffers size DATA_W from these with $bits.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_data_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [16:0] ctrl;
   } decode_data_t;

   localparam int DATA_W_DEFAULT = $bits(fetch_data_t);

   // One bundle at the default shape: per-lane valids plus packed lane payloads.
   typedef struct packed {
      logic [LANES_DEFAULT-1:0]                lane_valid;
      logic [LANES_DEFAULT*DATA_W_DEFAULT-1:0] data;
   } bundle_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two pipeline stages plus flush and occupancy.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready valid-ready pairs carried here.
interface pipe_stage_buf_if
   import pipe_pkg::*;
#(
   parameter int LANES  = LANES_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = 2
);
   logic                      flush;
   logic                      in_valid;
   logic [LANES-1:0]          in_lane_valid;
   logic [LANES*DATA_W-1:0]   in_data;
   logic                      in_ready;
   logic                      out_valid;
   logic [LANES-1:0]          out_lane_valid;
   logic [LANES*DATA_W-1:0]   out_data;
   logic                      out_ready;
   logic [$clog2(DEPTH):0]    count;

   // Stage-control side: drives upstream bundles, flush and downstream ready.
   modport master (
      output flush, in_valid, in_lane_valid, in_data, out_ready,
      input  in_ready, out_valid, out_lane_valid, out_data, count
   );

   // Buffer side.
   modport slave (
      input  flush, in_valid, in_lane_valid, in_data, out_ready,
      output in_ready, out_valid, out_lane_valid, out_data, count
   );
endinterface

// File: rtl/pipe_ring_ptr.sv
// Circular-buffer index that advances on request and wraps modulo DEPTH.
// Latency: new value visible one cycle after adv/clr.
// Backpressure: none; caller gates adv.
module pipe_ring_ptr
   import pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          adv,
   output logic [PW-1:0] ptr
);

   // DEPTH is a power of two, so natural overflow of the PW-bit add is the wrap.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= ptr + PW'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry bundle buffer between two stages; squashes bundles with no valid lane.
// Latency: one cycle from enqueue to out_*, no same-cycle bypass.
// Backpressure: in_ready from registered occupancy only; full buffer refuses input.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int LANES  = LANES_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = 2
) (
   input  logic            clk,
   input  logic            reset,
   pipe_stage_buf_if.slave stage
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [LANES-1:0]        lane_valid;
      logic [LANES*DATA_W-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   cnt;
   logic            not_full;
   logic            not_empty;
   logic            enq;
   logic            deq;

   // Handshake decode; flush suppresses both sides and empty bundles are never stored.
   always_comb begin
      not_full  = (cnt != CW'(DEPTH));
      not_empty = (cnt != '0);
      enq = stage.in_valid & not_full & ~stage.flush & (|stage.in_lane_valid);
      deq = not_empty & stage.out_ready & ~stage.flush;
   end

   pipe_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (stage.flush),
      .adv   (deq),
      .ptr   (rd_ptr)
   );

   pipe_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (stage.flush),
      .adv   (enq),
      .ptr   (wr_ptr)
   );

   // Occupancy tracks enq/deq; flush and reset empty the buffer outright.
   always_ff @(posedge clk) begin
      if (reset || stage.flush) begin
         cnt <= '0;
      end else begin
         case ({enq, deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage is deliberately left uncleared; outputs are masked when empty.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= '{lane_valid: stage.in_lane_valid, data: stage.in_data};
      end
   end

   // Head presentation, zeroed when nothing is stored.
   always_comb begin
      stage.in_ready       = not_full;
      stage.out_valid      = not_empty;
      stage.count          = cnt;
      stage.out_lane_valid = '0;
      stage.out_data       = '0;
      if (not_empty) begin
         stage.out_lane_valid = mem[rd_ptr].lane_valid;
         stage.out_data       = mem[rd_ptr].data;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector bench for pipe_stage_buf with a wrap/throughput sequence.
// Latency: checks one-cycle enqueue-to-output.
// Backpressure: exercises full-buffer stall, squash, flush and reset priority.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int LN = 4;
   localparam int DW = 64;
   localparam int DP = 2;
   localparam int NV = 22;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.LANES(LN), .DATA_W(DW), .DEPTH(DP)) bus ();

   pipe_stage_buf #(.LANES(LN), .DATA_W(DW), .DEPTH(DP)) u_dut (
      .clk   (clk),
      .reset (reset),
      .stage (bus)
   );

   typedef struct {
      logic         rst;
      logic         fl;
      logic         iv;
      logic [3:0]   lv;
      logic [255:0] d;
      logic         ordy;
      logic         e_ir;
      logic         e_ov;
      logic [3:0]   e_lv;
      logic [255:0] e_d;
      logic [1:0]   e_cnt;
   } vec_t;

   vec_t vt [NV];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [255:0] rep(input logic [63:0] v);
      return {v, v, v, v};
   endfunction

   function automatic vec_t mkv(input logic rst, input logic fl, input logic iv,
                                input logic [3:0] lv, input logic [255:0] d,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [3:0] e_lv, input logic [255:0] e_d,
                                input logic [1:0] e_cnt);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.lv = lv; v.d = d; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_lv = e_lv; v.e_d = e_d; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic [3:0] lv, input logic [255:0] d, input logic ordy);
      reset             = rst;
      bus.flush         = fl;
      bus.in_valid      = iv;
      bus.in_lane_valid = lv;
      bus.in_data       = d;
      bus.out_ready     = ordy;
   endtask

   logic [255:0] part;
   logic [63:0]  q [$];
   int           sent;
   int           rcvd;
   logic         orv;
   logic         ivv;

   initial begin
      part = {64'h0, 64'hCC, 64'h0, 64'hAA};

      //           rst fl iv lv       data        ordy  ir ov lv       exp data     cnt
      vt[0]  = mkv(1, 0, 0, 4'h0, '0,            0,    1, 0, 4'h0, '0,            2'd0);
      vt[1]  = mkv(1, 0, 1, 4'hF, rep(64'h9),    1,    1, 0, 4'h0, '0,            2'd0);
      vt[2]  = mkv(0, 0, 1, 4'hF, rep(64'h1),    1,    1, 1, 4'hF, rep(64'h1),    2'd1);
      vt[3]  = mkv(0, 0, 1, 4'hF, rep(64'h2),    1,    1, 1, 4'hF, rep(64'h2),    2'd1);
      vt[4]  = mkv(0, 0, 1, 4'hF, rep(64'h3),    1,    1, 1, 4'hF, rep(64'h3),    2'd1);
      vt[5]  = mkv(0, 0, 1, 4'hF, rep(64'h4),    1,    1, 1, 4'hF, rep(64'h4),    2'd1);
      vt[6]  = mkv(0, 0, 0, 4'h0, '0,            1,    1, 0, 4'h0, '0,            2'd0);
      vt[7]  = mkv(0, 0, 1, 4'hF, rep(64'hA),    0,    1, 1, 4'hF, rep(64'hA),    2'd1);
      vt[8]  = mkv(0, 0, 1, 4'hF, rep(64'hB),    0,    0, 1, 4'hF, rep(64'hA),    2'd2);
      vt[9]  = mkv(0, 0, 1, 4'hF, rep(64'hC),    0,    0, 1, 4'hF, rep(64'hA),    2'd2);
      vt[10] = mkv(0, 0, 1, 4'hF, rep(64'hC),    1,    1, 1, 4'hF, rep(64'hB),    2'd1);
      vt[11] = mkv(0, 0, 1, 4'hF, rep(64'hC),    1,    1, 1, 4'hF, rep(64'hC),    2'd1);
      vt[12] = mkv(0, 0, 0, 4'h0, '0,            1,    1, 0, 4'h0, '0,            2'd0);
      vt[13] = mkv(0, 0, 1, 4'h0, rep(64'h55),   0,    1, 0, 4'h0, '0,            2'd0);
      vt[14] = mkv(0, 0, 1, 4'h5, part,          0,    1, 1, 4'h5, part,          2'd1);
      vt[15] = mkv(0, 0, 1, 4'hF, rep(64'hD),    0,    0, 1, 4'h5, part,          2'd2);
      vt[16] = mkv(0, 1, 1, 4'hF, rep(64'hE),    0,    1, 0, 4'h0, '0,            2'd0);
      vt[17] = mkv(0, 0, 0, 4'h0, '0,            1,    1, 0, 4'h0, '0,            2'd0);
      vt[18] = mkv(0, 0, 1, 4'hF, rep(64'h11),   0,    1, 1, 4'hF, rep(64'h11),   2'd1);
      vt[19] = mkv(0, 1, 0, 4'h0, '0,            1,    1, 0, 4'h0, '0,            2'd0);
      vt[20] = mkv(0, 0, 1, 4'hF, rep(64'h21),   0,    1, 1, 4'hF, rep(64'h21),   2'd1);
      vt[21] = mkv(1, 0, 1, 4'hF, rep(64'h22),   1,    1, 0, 4'h0, '0,            2'd0);

      drive(1'b1, 1'b0, 1'b0, 4'h0, '0, 1'b0);
      @(negedge clk);

      // Each vector is driven at a falling edge and checked at the next one.
      for (int i = 0; i < NV; i++) begin
         drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].lv, vt[i].d, vt[i].ordy);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d.in_ready", i),  bus.in_ready,       vt[i].e_ir);
         chk($sformatf("v%0d.out_valid", i), bus.out_valid,      vt[i].e_ov);
         chk($sformatf("v%0d.lane_valid", i), bus.out_lane_valid, vt[i].e_lv);
         chk($sformatf("v%0d.out_data", i),  bus.out_data,       vt[i].e_d);
         chk($sformatf("v%0d.count", i),     bus.count,          vt[i].e_cnt);
      end

      // Ten bundles with out_ready alternating: order, occupancy bound and pointer wrap.
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
         orv = (cyc % 2 == 0);
         ivv = (sent < 10);
         drive(1'b0, 1'b0, ivv, 4'hF, rep(64'h100 + 64'(sent)), orv);
         chk($sformatf("wrap%0d.cnt_le2", cyc), bus.count <= 2'd2, 1'b1);
         chk($sformatf("wrap%0d.out_valid", cyc), bus.out_valid, q.size() != 0);
         if (bus.out_valid && q.size() != 0) begin
            chk($sformatf("wrap%0d.out_data", cyc), bus.out_data, rep(q[0]));
            if (orv) begin
               void'(q.pop_front());
               rcvd++;
            end
         end
         if (ivv && bus.in_ready) begin
            q.push_back(64'h100 + 64'(sent));
            sent++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("wrap.received", 256'(rcvd), 256'd10);
      chk("wrap.drained", bus.out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
